// File: rtl/switch_fabric_elastic_pkg.sv
// Shared constants, slot state encoding and select helpers for the elastic crossbar.
// Channel width and port indices are the values the output schedulers also use.
package switch_fabric_elastic_pkg;

   localparam int CHANNEL_WIDTH = 32;

   localparam int PORT_PE   = 0;
   localparam int PORT_XPOS = 1;
   localparam int PORT_YPOS = 2;
   localparam int PORT_XNEG = 3;
   localparam int PORT_YNEG = 4;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_ONE   = 2'd1,
      SLOT_FULL  = 2'd2
   } slot_state_e;

   // True for an all-zero (idle) or one-hot select vector.
   function automatic logic onehot0(input logic [31:0] v);
      return ($countones(v) <= 1);
   endfunction

endpackage

// File: rtl/switch_fabric_elastic_if.sv
// Crossbar data/handshake bundle. A flit moves on a port when valid and ready are
// both high at the clock edge; valid must not depend on ready.
interface switch_fabric_elastic_if
   import switch_fabric_elastic_pkg::*;
#(
   parameter int PORTS      = 5,
   parameter int DATA_WIDTH = CHANNEL_WIDTH
);
   logic [PORTS*DATA_WIDTH-1:0] in_data;
   logic [PORTS-1:0]            in_valid;
   logic [PORTS-1:0]            in_ready;
   logic [PORTS*PORTS-1:0]      conf;
   logic [PORTS*DATA_WIDTH-1:0] out_data;
   logic [PORTS-1:0]            out_valid;
   logic [PORTS-1:0]            out_ready;
   logic [PORTS-1:0]            conf_err;

   modport master (
      output in_data, in_valid, conf, out_ready,
      input  in_ready, out_data, out_valid, conf_err
   );

   modport slave (
      input  in_data, in_valid, conf, out_ready,
      output in_ready, out_data, out_valid, conf_err
   );
endinterface

// File: rtl/xbar_out_slot.sv
// Two-entry elastic buffer owned by one crossbar output: head register plus a
// skid register that absorbs the flit in flight when the downstream stalls.
module xbar_out_slot
   import switch_fabric_elastic_pkg::*;
#(
   parameter int DATA_WIDTH = CHANNEL_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  ready,
   output logic                  space,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output slot_state_e           state
);

   slot_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, skid_q;
   logic                  pop;

   assign pop   = valid & ready;
   assign space = (state_q != SLOT_FULL);
   assign valid = (state_q != SLOT_EMPTY);
   assign data  = head_q;
   assign state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: if (load) state_d = SLOT_ONE;
         SLOT_ONE: begin
            if (load && !pop)      state_d = SLOT_FULL;
            else if (pop && !load) state_d = SLOT_EMPTY;
         end
         SLOT_FULL:  if (pop) state_d = SLOT_ONE;
         default:    state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            SLOT_EMPTY: if (load) head_q <= load_data;
            SLOT_ONE: begin
               if (load && pop) head_q <= load_data;
               else if (load)   skid_q <= load_data;
            end
            SLOT_FULL:  if (pop) head_q <= skid_q;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/switch_fabric_elastic.sv
// N-port crossbar: per-output select legality, AND-OR data mux and in_ready
// reduction over registered slot space, so out_ready never reaches in_ready.
module switch_fabric_elastic
   import switch_fabric_elastic_pkg::*;
#(
   parameter int PORTS       = 5,
   parameter int DATA_WIDTH  = CHANNEL_WIDTH,
   parameter int ALLOW_UTURN = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   switch_fabric_elastic_if.slave bus,
   output logic [2*PORTS-1:0]     slot_state
);

   logic [PORTS-1:0]      sel [PORTS];
   logic [PORTS-1:0]      col [PORTS];
   logic [PORTS-1:0]      legal, space, load, in_ready, valid_w, conf_err_q;
   logic [DATA_WIDTH-1:0] mux_data [PORTS];
   logic [DATA_WIDTH-1:0] data_w   [PORTS];
   slot_state_e           state_w  [PORTS];

   genvar o, i;
   generate
      for (o = 0; o < PORTS; o++) begin : g_out
         logic [PORTS-1:0] raw;
         assign raw      = bus.conf[o*PORTS +: PORTS];
         assign legal[o] = onehot0(32'(raw)) && ((ALLOW_UTURN != 0) || !raw[o]);
         // Illegal selects behave exactly like idle ones.
         assign sel[o]   = legal[o] ? raw : '0;
         assign load[o]  = |(sel[o] & bus.in_valid & in_ready);

         always_comb begin
            mux_data[o] = '0;
            for (int k = 0; k < PORTS; k++)
               mux_data[o] = mux_data[o] |
                  (bus.in_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[o][k]}});
         end

         xbar_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[o]),
            .load_data (mux_data[o]),
            .ready     (bus.out_ready[o]),
            .space     (space[o]),
            .valid     (valid_w[o]),
            .data      (data_w[o]),
            .state     (state_w[o])
         );
      end

      for (i = 0; i < PORTS; i++) begin : g_in
         for (o = 0; o < PORTS; o++) begin : g_col
            assign col[i][o] = sel[o][i];
         end
         // Every output that legally selects this input must have room (multicast).
         assign in_ready[i] = !reset && (|col[i]) && (&(space | ~col[i]));
      end
   endgenerate

   always_comb begin
      bus.out_data = '0;
      slot_state   = '0;
      for (int k = 0; k < PORTS; k++) begin
         bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = data_w[k];
         slot_state[2*k +: 2]                     = state_w[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) conf_err_q <= '0;
      else       conf_err_q <= ~legal;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_w;
   assign bus.conf_err  = conf_err_q;

endmodule
